fs_dither_stream: RTL and testbench

//  Streaming Floyd-Steinberg error-diffusion ditherer, parametrised in pixel width, output depth and frame size.

---
 rtl/fs_dither_stream.sv | 253 +++++++++++++++++++++++++
 tb/tb_fs_dither_stream.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fs_dither_stream.sv
`default_nettype none
// ============================================================================
// Module      : fs_dither_stream
// Description : Streaming Floyd-Steinberg error-diffusion ditherer. Takes
//               grey pixels tagged with (hcount, vcount), quantises them to
//               OUT_W bits while diffusing the quantisation error right and
//               into the next row, and emits the pixel together with its
//               frame-buffer address two cycles later.
//
// Ports       : clk_in        pixel clock
//               rst_in        synchronous reset, active-low
//               pixel_in      grey pixel (PIX_W)
//               hcount_in     pixel column (11)
//               vcount_in     pixel row (10)
//               valid_in      single-cycle pixel strobe
//               threshold_in  decision threshold, used only when OUT_W == 1
//               bypass_in     plain quantisation, no diffusion
//                             (present only with DITHER_BYPASS_EN defined)
//               pixel_out     quantised pixel (OUT_W)
//               hcount_out    column of pixel_out
//               vcount_out    row of pixel_out
//               addr_out      hcount_out + H_PIXELS * vcount_out
//               valid_out     single-cycle output strobe
//
// Config      : `define DITHER_BYPASS_EN to add the bypass_in port.
//
// Revision    : 1.0  initial release
// ============================================================================
module fs_dither_stream #(
    parameter int PIX_W    = 8,
    parameter int OUT_W    = 1,
    parameter int H_PIXELS = 320,
    parameter int V_LINES  = 240,
    parameter int ERR_W    = PIX_W + 3
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic [PIX_W-1:0]                      pixel_in,
    input  logic [10:0]                           hcount_in,
    input  logic [9:0]                            vcount_in,
    input  logic                                  valid_in,
    input  logic [PIX_W-1:0]                      threshold_in,
`ifdef DITHER_BYPASS_EN
    input  logic                                  bypass_in,
`endif
    output logic [OUT_W-1:0]                      pixel_out,
    output logic [10:0]                           hcount_out,
    output logic [9:0]                            vcount_out,
    output logic [$clog2(H_PIXELS*V_LINES)-1:0]   addr_out,
    output logic                                  valid_out
);

    localparam int c_addr_w = $clog2(H_PIXELS * V_LINES);
    localparam int c_idx_w  = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam logic [10:0] c_h_num  = 11'(H_PIXELS);
    localparam logic [10:0] c_h_last = 11'(H_PIXELS - 1);
    localparam logic [9:0]  c_v_num  = 10'(V_LINES);
    localparam logic [9:0]  c_v_last = 10'(V_LINES - 1);
    localparam logic signed [ERR_W-1:0] c_pix_max = ERR_W'((1 << PIX_W) - 1);

    logic w_byp_in;
`ifdef DITHER_BYPASS_EN
    assign w_byp_in = bypass_in;
`else
    assign w_byp_in = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Stage 0: accept in-range pixels, fetch previous-row error
    // ------------------------------------------------------------------
    logic w_accept;
    assign w_accept = valid_in && (hcount_in < c_h_num) && (vcount_in < c_v_num);

    logic                    r_s0_valid;
    logic [PIX_W-1:0]        r_s0_pix;
    logic [PIX_W-1:0]        r_s0_thr;
    logic [10:0]             r_s0_h;
    logic [9:0]              r_s0_v;
    logic                    r_s0_byp;
    logic signed [ERR_W-1:0] r_s0_rowerr;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_s0_valid <= 1'b0;
            r_s0_pix   <= '0;
            r_s0_thr   <= '0;
            r_s0_h     <= '0;
            r_s0_v     <= '0;
            r_s0_byp   <= 1'b0;
        end else begin
            r_s0_valid <= w_accept;
            if (w_accept) begin
                r_s0_pix <= pixel_in;
                r_s0_thr <= threshold_in;
                r_s0_h   <= hcount_in;
                r_s0_v   <= vcount_in;
                r_s0_byp <= w_byp_in;
            end
        end
    end

    // Row memory holds the diffused error destined for the next row. The
    // read of column h always lands before this row overwrites column h,
    // because column h is only written once pixel h+1 reaches stage 1.
    logic signed [ERR_W-1:0] r_row_ram [0:H_PIXELS-1];
    logic                    w_ram_we;
    logic [c_idx_w-1:0]      w_ram_waddr;
    logic signed [ERR_W-1:0] w_ram_wdata;

    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            r_s0_rowerr <= ((vcount_in == 10'd0) || w_byp_in) ? '0
                           : r_row_ram[hcount_in[c_idx_w-1:0]];
        end
        if (w_ram_we) begin
            r_row_ram[w_ram_waddr] <= w_ram_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: correct, quantise, split error
    // ------------------------------------------------------------------
    logic                    r_last_ok;
    logic [10:0]             r_last_h;
    logic [9:0]              r_last_v;
    logic signed [ERR_W-1:0] r_carry;
    logic signed [ERR_W-1:0] r_acc_a;     // next-row entry at column h-1
    logic signed [ERR_W-1:0] r_acc_b;     // next-row entry at column h
    logic                    r_flush;
    logic signed [ERR_W-1:0] r_flush_data;

    logic                    w_carry_use;
    logic                    w_first;
    logic                    w_h_end;
    logic                    w_v_end;
    logic signed [ERR_W-1:0] w_v_raw;
    logic [PIX_W-1:0]        w_v;
    logic [PIX_W-1:0]        w_recon;
    logic [OUT_W-1:0]        w_q;
    logic signed [ERR_W-1:0] w_err;
    logic signed [ERR_W+2:0] w_ex, w_p7, w_p3, w_p5, w_s7, w_s3, w_s5, w_s1;
    logic signed [ERR_W-1:0] w_r7, w_bl3, w_b5, w_br1;
    logic signed [ERR_W-1:0] w_base_a, w_base_b;
    logic [c_addr_w-1:0]     w_addr;

    // Carry only chains along an unbroken run of the same line.
    assign w_carry_use = r_last_ok && (r_last_v == r_s0_v)
                         && ((r_last_h + 11'd1) == r_s0_h) && !r_s0_byp;
    assign w_first = (r_s0_h == 11'd0);
    assign w_h_end = (r_s0_h == c_h_last);
    assign w_v_end = (r_s0_v == c_v_last);

    assign w_v_raw = $signed({{(ERR_W-PIX_W){1'b0}}, r_s0_pix})
                     + (w_carry_use ? r_carry : '0) + r_s0_rowerr;

    always_comb begin
        w_v = w_v_raw[PIX_W-1:0];
        if (w_v_raw[ERR_W-1]) begin
            w_v = '0;
        end else if (w_v_raw > c_pix_max) begin
            w_v = '1;
        end
    end

    if (OUT_W == 1) begin : g_q_bin
        assign w_q     = {OUT_W{w_v >= r_s0_thr}};
        assign w_recon = {PIX_W{w_q[0]}};
    end else begin : g_q_multi
        assign w_q = w_v[PIX_W-1 -: OUT_W];
        // Replicate the code MSB-first so full scale maps to all-ones.
        for (genvar i = 0; i < PIX_W; i++) begin : g_rep
            assign w_recon[PIX_W-1-i] = w_q[OUT_W-1-(i % OUT_W)];
        end
        logic w_unused_thr;
        assign w_unused_thr = ^{r_s0_thr, w_v};
    end

    assign w_err = r_s0_byp ? '0
                   : $signed({{(ERR_W-PIX_W){1'b0}}, w_v})
                     - $signed({{(ERR_W-PIX_W){1'b0}}, w_recon});

    // Three guard bits keep 7*e exact before the floor-shift by 4.
    assign w_ex  = {{3{w_err[ERR_W-1]}}, w_err};
    assign w_p7  = (w_ex <<< 3) - w_ex;
    assign w_p3  = (w_ex <<< 1) + w_ex;
    assign w_p5  = (w_ex <<< 2) + w_ex;
    assign w_s7  = w_p7 >>> 4;
    assign w_s3  = w_p3 >>> 4;
    assign w_s5  = w_p5 >>> 4;
    assign w_s1  = w_ex >>> 4;
    assign w_r7  = w_s7[ERR_W-1:0];
    assign w_bl3 = w_s3[ERR_W-1:0];
    assign w_b5  = w_s5[ERR_W-1:0];
    assign w_br1 = w_s1[ERR_W-1:0];

    // Column 0 starts a fresh window (also covers mid-frame restarts).
    assign w_base_a = w_first ? '0 : r_acc_a;
    assign w_base_b = w_first ? '0 : r_acc_b;

    assign w_addr = c_addr_w'(r_s0_h) + c_addr_w'(H_PIXELS) * c_addr_w'(r_s0_v);

    // Pixel writes take column h-1; the line-end flush writes the last
    // column one cycle later, when no pixel can be in stage 1.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = r_s0_h[c_idx_w-1:0] - c_idx_w'(1);
        w_ram_wdata = r_s0_byp ? '0 : (w_base_a + w_bl3);
        if (r_s0_valid && !w_first && !w_v_end) begin
            w_ram_we = rst_in;
        end else if (r_flush) begin
            w_ram_we    = rst_in;
            w_ram_waddr = c_h_last[c_idx_w-1:0];
            w_ram_wdata = r_flush_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            valid_out    <= 1'b0;
            pixel_out    <= '0;
            hcount_out   <= '0;
            vcount_out   <= '0;
            addr_out     <= '0;
            r_last_ok    <= 1'b0;
            r_last_h     <= '0;
            r_last_v     <= '0;
            r_carry      <= '0;
            r_acc_a      <= '0;
            r_acc_b      <= '0;
            r_flush      <= 1'b0;
            r_flush_data <= '0;
        end else begin
            valid_out <= r_s0_valid;
            r_flush   <= 1'b0;
            if (r_s0_valid) begin
                pixel_out    <= w_q;
                hcount_out   <= r_s0_h;
                vcount_out   <= r_s0_v;
                addr_out     <= w_addr;
                r_last_ok    <= 1'b1;
                r_last_h     <= r_s0_h;
                r_last_v     <= r_s0_v;
                r_carry      <= w_h_end ? '0 : w_r7;
                r_acc_a      <= w_base_b + w_b5;
                r_acc_b      <= w_h_end ? '0 : w_br1;
                r_flush      <= w_h_end && !w_v_end;
                r_flush_data <= r_s0_byp ? '0 : (w_base_b + w_b5);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fs_dither_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_fs_dither_stream
// Description : Directed self-checking bench for fs_dither_stream on an
//               8x4 frame, 8-bit input, 1-bit output.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fs_dither_stream;

    localparam int PIX_W = 8;
    localparam int OUT_W = 1;
    localparam int H     = 8;
    localparam int V     = 4;
    localparam int AW    = $clog2(H * V);

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [PIX_W-1:0]  pixel_in;
    logic [10:0]       hcount_in;
    logic [9:0]        vcount_in;
    logic              valid_in;
    logic [PIX_W-1:0]  threshold_in;
`ifdef DITHER_BYPASS_EN
    logic              bypass_in;
`endif
    logic [OUT_W-1:0]  pixel_out;
    logic [10:0]       hcount_out;
    logic [9:0]        vcount_out;
    logic [AW-1:0]     addr_out;
    logic              valid_out;

    always #5 clk_in = ~clk_in;

    fs_dither_stream #(
        .PIX_W    (PIX_W),
        .OUT_W    (OUT_W),
        .H_PIXELS (H),
        .V_LINES  (V)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .pixel_in     (pixel_in),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .valid_in     (valid_in),
        .threshold_in (threshold_in),
`ifdef DITHER_BYPASS_EN
        .bypass_in    (bypass_in),
`endif
        .pixel_out    (pixel_out),
        .hcount_out   (hcount_out),
        .vcount_out   (vcount_out),
        .addr_out     (addr_out),
        .valid_out    (valid_out)
    );

    typedef struct packed {
        logic [AW-1:0]    a;
        logic [OUT_W-1:0] p;
    } out_t;

    out_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    bit   prev_end = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (valid_out === 1'b1) q.push_back({addr_out, pixel_out});
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic px(input int h, input int v, input int p, input int thr);
        @(negedge clk_in);
        if (prev_end) chk("line_gap", (cyc - last_cyc >= 3) ? 1 : 0, 1);
        prev_end     = (h == H - 1);
        last_cyc     = cyc;
        valid_in     = 1'b1;
        hcount_in    = 11'(h);
        vcount_in    = 10'(v);
        pixel_in     = 8'(p);
        threshold_in = 8'(thr);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_in);
            valid_in = 1'b0;
        end
    endtask

    task automatic pop(input string tag, input int h, input int v, input int p);
        out_t o;
        chk({tag, "_present"}, (q.size() > 0) ? 1 : 0, 1);
        if (q.size() > 0) begin
            o = q.pop_front();
            chk({tag, "_pix"}, int'(o.p), p);
            chk({tag, "_addr"}, int'(o.a), h + H * v);
        end
    endtask

    initial begin
        // Reset held with a valid pixel on the inputs
        rst_in = 1'b0; valid_in = 1'b1; pixel_in = 8'd255;
        hcount_in = 11'd5; vcount_in = 10'd2; threshold_in = 8'd0;
`ifdef DITHER_BYPASS_EN
        bypass_in = 1'b0;
`endif
        repeat (3) begin
            @(negedge clk_in);
            chk("rst_valid", int'(valid_out), 0);
            chk("rst_pix", int'(pixel_out), 0);
            chk("rst_addr", int'(addr_out), 0);
        end
        rst_in = 1'b1; valid_in = 1'b0;
        idle(3);
        chk("rst_no_output", q.size(), 0);

        // Row 0 of mid-grey alternates
        for (int h = 0; h < H; h++) px(h, 0, 128, 128);
        idle(3);
        for (int h = 0; h < H; h++) pop("row0_128", h, 0, (h % 2 == 0) ? 1 : 0);

        // Row 1 picks up the error diffused from row 0 (-27, -4)
        px(0, 1, 150, 128);
        px(1, 1, 77, 128);
        idle(3);
        pop("row1_h0", 0, 1, 0);
        pop("row1_h1", 1, 1, 0);

        // Two-cycle latency and address
        px(5, 2, 255, 0);
        @(negedge clk_in);
        valid_in = 1'b0;
        chk("lat_n1_valid", int'(valid_out), 0);
        @(negedge clk_in);
        chk("lat_n2_valid", int'(valid_out), 1);
        chk("lat_h", int'(hcount_out), 5);
        chk("lat_v", int'(vcount_out), 2);
        chk("lat_addr", int'(addr_out), 21);
        chk("lat_pix", int'(pixel_out), 1);
        @(negedge clk_in);
        chk("lat_strobe_drop", int'(valid_out), 0);
        idle(2);
        q.delete();

        // Out-of-range pixels dropped without disturbing the carry chain
        px(0, 0, 128, 128);
        px(8, 0, 0, 128);
        px(3, 4, 0, 128);
        px(1, 0, 128, 128);
        idle(3);
        chk("drop_count", q.size(), 2);
        pop("drop_h0", 0, 0, 1);
        pop("drop_h1", 1, 0, 0);

        // Reset mid-line squashes the in-flight pixel and clears the carry
        px(2, 0, 128, 128);
        @(negedge clk_in);
        valid_in = 1'b0; rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        idle(2);
        chk("rst_squash", q.size(), 0);
        px(2, 0, 100, 128);
        idle(3);
        pop("rst_fresh", 2, 0, 0);

        // Frame restart after dark rows ignores earlier error
        for (int v = 0; v < 2; v++) begin
            for (int h = 0; h < H; h++) px(h, v, 40, 128);
            idle(3);
        end
        q.delete();
        px(0, 0, 128, 128);
        px(1, 0, 128, 128);
        idle(3);
        pop("restart_h0", 0, 0, 1);
        pop("restart_h1", 1, 0, 0);

`ifdef DITHER_BYPASS_EN
        bypass_in = 1'b1;
        for (int h = 0; h < H; h++) px(h, 0, 128, 128);
        idle(3);
        for (int h = 0; h < H; h++) pop("bypass_128", h, 0, 1);
        bypass_in = 1'b0;
`endif

        // Full black then full white frames
        for (int f = 0; f < 2; f++) begin
            q.delete();
            for (int v = 0; v < V; v++) begin
                for (int h = 0; h < H; h++) px(h, v, (f == 0) ? 0 : 255, 128);
                idle(3);
            end
            chk("frame_count", q.size(), H * V);
            for (int v = 0; v < V; v++)
                for (int h = 0; h < H; h++)
                    pop((f == 0) ? "frame_black" : "frame_white", h, v, f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
